// File: rtl/serial_add_unit_if.sv
// Operand/result handshake bundle for serial_add_unit; master drives operands and out_ready.
interface serial_add_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, carry, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, carry, overflow, zero
  );
endinterface

// File: rtl/serial_add_unit.sv
// Serial add/sub, one 2-bit adder slice reused per cycle; result WIDTH/2 cycles after accept.
// Accepts only in IDLE; the result is held in DONE until out_ready, so no input is taken meanwhile.
module serial_add_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_unit_if.slave bus
);
  localparam int DIGITS = WIDTH / 2;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last_digit;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] b_eff;
  logic             carry_reg;
  logic             sign_a;
  logic             sign_b;
  logic [CW-1:0]    count;
  logic [1:0]       slice_out;
  logic             slice_cout;
  logic [WIDTH-1:0] res_nxt;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             overflow_r;
  logic             zero_r;

  assign b_eff = bus.sub ? ~bus.b : bus.b;

  // The single ADDER2BIT slice: the low digit pair of the shifting operands plus the running carry.
  assign {slice_cout, slice_out} = {1'b0, a_sh[1:0]} + {1'b0, b_sh[1:0]} + {2'b00, carry_reg};

  // Digits enter from the top, so after the last slice res_nxt is the complete sum.
  generate
    if (WIDTH == 2) begin : g_one_digit
      assign res_nxt = slice_out;
    end else begin : g_multi_digit
      logic [WIDTH-3:0] acc;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          acc <= '0;
        end else if (state == RUN) begin
          acc <= res_nxt[WIDTH-1:2];
        end
      end
      assign res_nxt = {slice_out, acc};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    accept        = 1'b0;
    last_digit    = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (count == LAST) begin
          last_digit = 1'b1;
          state_nxt  = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      carry_reg  <= 1'b0;
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      count      <= '0;
      sum_r      <= '0;
      carry_r    <= 1'b0;
      overflow_r <= 1'b0;
      zero_r     <= 1'b0;
    end else if (accept) begin
      a_sh      <= bus.a;
      b_sh      <= b_eff;
      carry_reg <= bus.sub;
      sign_a    <= bus.a[WIDTH-1];
      sign_b    <= b_eff[WIDTH-1];
      count     <= '0;
    end else if (state == RUN) begin
      a_sh      <= a_sh >> 2;
      b_sh      <= b_sh >> 2;
      carry_reg <= slice_cout;
      count     <= count + 1'b1;
      // Visible results change only on DONE entry; they hold through IDLE and RUN.
      if (last_digit) begin
        sum_r      <= res_nxt;
        carry_r    <= slice_cout;
        overflow_r <= (sign_a == sign_b) && (res_nxt[WIDTH-1] != sign_a);
        zero_r     <= (res_nxt == '0);
      end
    end
  end

  assign bus.sum      = sum_r;
  assign bus.carry    = carry_r;
  assign bus.overflow = overflow_r;
  assign bus.zero     = zero_r;
endmodule

// File: tb/tb_serial_add_unit.sv
// Bench for serial_add_unit: directed literal cases and random ops on WIDTH=32, random ops on WIDTH=2 and 8.
module tb_serial_add_unit;
  typedef struct packed {
    logic [31:0] sum;
    logic        carry;
    logic        ov;
    logic        zero;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  logic go = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   narrow_done = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  serial_add_unit_if #(.WIDTH(32)) ifc ();
  serial_add_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic note_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timed out", nm);
  endtask

  // Integer-arithmetic reference for a w-bit add/sub.
  function automatic res_t ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                     input logic s);
    longint m, ua, ub, sa, sb, ur, sr;
    res_t r;
    m  = longint'(1) << w;
    ua = longint'({32'd0, a}) % m;
    ub = longint'({32'd0, b}) % m;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (s) begin
      ur = ua - ub;
      sr = sa - sb;
      r.carry = (ua >= ub);
    end else begin
      ur = ua + ub;
      sr = sa + sb;
      r.carry = (ur >= m);
    end
    r.ov   = (sr >= m / 2) || (sr < -(m / 2));
    ur     = ((ur % m) + m) % m;
    r.sum  = 32'(ur);
    r.zero = (ur == 0);
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  // Scoreboard: every accept pushes the model result; every DONE cycle is checked against the head.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (ifc.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mon_unexpected_out_valid actual=1 required=0");
        end else begin
          chk("mon_sum", 64'(ifc.sum), 64'(exp_q[0].sum));
          chk("mon_carry", 64'(ifc.carry), 64'(exp_q[0].carry));
          chk("mon_overflow", 64'(ifc.overflow), 64'(exp_q[0].ov));
          chk("mon_zero", 64'(ifc.zero), 64'(exp_q[0].zero));
          if (ifc.out_ready) void'(exp_q.pop_front());
        end
      end
      if (ifc.in_valid && ifc.in_ready) exp_q.push_back(ref_model(32, ifc.a, ifc.b, ifc.sub));
    end
  end

  // All drivers run at #1 after a rising edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s);
    int n = 0;
    while (!ifc.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) note_fail("send_in_ready");
    ifc.in_valid = 1'b1;
    ifc.a = a;
    ifc.b = b;
    ifc.sub = s;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    ifc.a = $urandom;
    ifc.b = $urandom;
    ifc.sub = 1'($urandom);
  endtask

  task automatic wait_done(output int lat);
    int n = 0;
    while (!ifc.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) note_fail("wait_out_valid");
    lat = n;
  endtask

  task automatic take(input int stall);
    repeat (stall) begin
      @(posedge clk); #1;
    end
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
  endtask

  task automatic op_lit(input string nm, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] es, input logic ec, input logic eo, input logic ez);
    int lat;
    send(a, b, s);
    wait_done(lat);
    chk({nm, "_latency"}, 64'(lat), 64'd16);
    chk({nm, "_sum"}, 64'(ifc.sum), 64'(es));
    chk({nm, "_carry"}, 64'(ifc.carry), 64'(ec));
    chk({nm, "_overflow"}, 64'(ifc.overflow), 64'(eo));
    chk({nm, "_zero"}, 64'(ifc.zero), 64'(ez));
    take(1);
  endtask

  // Narrow builds: own driver, per-op check against the same model.
  for (genvar gi = 0; gi < 2; gi++) begin : g_nar
    localparam int W = (gi == 0) ? 2 : 8;
    serial_add_unit_if #(.WIDTH(W)) nif ();
    serial_add_unit #(.WIDTH(W)) ndut (.clk(clk), .rst_n(rst_n), .bus(nif));

    initial begin
      logic [W-1:0] ra, rb;
      logic rs;
      res_t e;
      int n;
      nif.in_valid = 1'b0;
      nif.out_ready = 1'b0;
      nif.a = '0;
      nif.b = '0;
      nif.sub = 1'b0;
      wait (go);
      @(posedge clk); #1;
      for (int k = 0; k < 600; k++) begin
        ra = W'($urandom);
        rb = W'($urandom);
        rs = 1'($urandom);
        n = 0;
        while (!nif.in_ready && n < 100) begin
          @(posedge clk); #1;
          n++;
        end
        nif.in_valid = 1'b1;
        nif.a = ra;
        nif.b = rb;
        nif.sub = rs;
        @(posedge clk); #1;
        nif.in_valid = 1'b0;
        nif.a = W'($urandom);
        nif.b = W'($urandom);
        n = 0;
        while (!nif.out_valid && n < 100) begin
          @(posedge clk); #1;
          n++;
        end
        chk($sformatf("w%0d_latency", W), 64'(n), 64'(W / 2));
        e = ref_model(W, 32'(ra), 32'(rb), rs);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        chk($sformatf("w%0d_sum", W), 64'(nif.sum), 64'(e.sum[W-1:0]));
        chk($sformatf("w%0d_carry", W), 64'(nif.carry), 64'(e.carry));
        chk($sformatf("w%0d_overflow", W), 64'(nif.overflow), 64'(e.ov));
        chk($sformatf("w%0d_zero", W), 64'(nif.zero), 64'(e.zero));
        nif.out_ready = 1'b1;
        @(posedge clk); #1;
        nif.out_ready = 1'b0;
      end
      narrow_done++;
    end
  end

  initial begin
    #900000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lat;
    rst_n = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b0;
    ifc.a = '0;
    ifc.b = '0;
    ifc.sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    chk("rst_in_ready", 64'(ifc.in_ready), 64'd1);
    chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst_sum", 64'(ifc.sum), 64'd0);
    chk("rst_carry", 64'(ifc.carry), 64'd0);
    chk("rst_overflow", 64'(ifc.overflow), 64'd0);
    chk("rst_zero", 64'(ifc.zero), 64'd0);

    op_lit("add_5_3", 32'h5, 32'h3, 1'b0, 32'h8, 1'b0, 1'b0, 1'b0);
    chk("idle_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("idle_in_ready", 64'(ifc.in_ready), 64'd1);
    chk("idle_sum_held", 64'(ifc.sum), 64'h8);
    op_lit("add_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    op_lit("add_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    op_lit("sub_5_5", 32'h5, 32'h5, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
    op_lit("sub_3_5", 32'h3, 32'h5, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    op_lit("sub_ovf", 32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

    // in_valid held with changing operands: only the first op counts.
    ifc.in_valid = 1'b1;
    ifc.a = 32'd10;
    ifc.b = 32'd20;
    ifc.sub = 1'b0;
    @(posedge clk); #1;
    n = 0;
    while (!ifc.out_valid && n < 100) begin
      chk("hold_in_ready_run", 64'(ifc.in_ready), 64'd0);
      ifc.a = $urandom;
      ifc.b = $urandom;
      ifc.sub = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    chk("hold_latency", 64'(n), 64'd16);
    repeat (5) begin
      chk("stall_in_ready", 64'(ifc.in_ready), 64'd0);
      chk("stall_out_valid", 64'(ifc.out_valid), 64'd1);
      chk("stall_sum", 64'(ifc.sum), 64'd30);
      @(posedge clk); #1;
    end
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    chk("handoff_no_accept_in_ready", 64'(ifc.in_ready), 64'd1);
    chk("handoff_out_valid", 64'(ifc.out_valid), 64'd0);
    ifc.in_valid = 1'b0;
    chk("handoff_sum_held", 64'(ifc.sum), 64'd30);

    // Abort an op mid-RUN at count 7.
    send(32'h1234_5678, 32'h0FED_CBA9, 1'b0);
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_in_ready", 64'(ifc.in_ready), 64'd1);
    chk("abort_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("abort_sum", 64'(ifc.sum), 64'd0);
    chk("abort_zero", 64'(ifc.zero), 64'd0);
    op_lit("after_abort", 32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 32'hCD9C_ADDE, 1'b1, 1'b0, 1'b0);

    go = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      logic [31:0] ra, rb;
      ra = pick();
      rb = pick();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send(ra, rb, 1'($urandom));
      wait_done(lat);
      chk("rand_latency", 64'(lat), 64'd16);
      take($urandom_range(0, 3));
    end

    n = 0;
    while (narrow_done < 2 && n < 40000) begin
      @(posedge clk);
      n++;
    end
    chk("narrow_builds_done", 64'(narrow_done), 64'd2);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
